muldiv_unit: RTL and testbench



---
 rtl/muldiv_unit.sv | 195 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
//==============================================================================
// Module      : muldiv_unit
// Description : Iterative MIPS multiply/divide unit with HI/LO registers.
//               Shift-add multiply and restoring divide on operand magnitudes,
//               one bit per cycle, sign fix-up in a final cycle.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [5:0]       c_fn_mthi = 6'h11;
    localparam logic [5:0]       c_fn_mtlo = 6'h13;
    localparam logic [CNT_W-1:0] c_last    = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [CNT_W-1:0]     r_cnt;
    logic [2*WIDTH-1:0]   r_acc;      // mult: {partial product, multiplier}; div: {remainder, dividend/quotient}
    logic [WIDTH-1:0]     r_opnd;     // multiplicand magnitude or divisor magnitude
    logic                 r_is_div;
    logic                 r_sign_a;
    logic                 r_sign_b;
    logic                 r_div_zero;
    logic                 r_done;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;

    logic                 w_idle;
    logic                 w_is_muldiv;
    logic                 w_accept;
    logic                 w_signed;
    logic [WIDTH-1:0]     w_mag_a;
    logic [WIDTH-1:0]     w_mag_b;
    logic [WIDTH:0]       w_msum;
    logic [WIDTH:0]       w_dtop;
    logic [WIDTH:0]       w_dsub;
    logic                 w_dge;
    logic [2*WIDTH-1:0]   w_step;
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH-1:0]     w_quot;
    logic [WIDTH-1:0]     w_rem;

    // Request decode and operand magnitudes (funct[1] selects divide, funct[0] unsigned)
    always_comb begin
        w_idle      = (r_state == S_IDLE);
        w_is_muldiv = (funct[5:2] == 4'b0110);
        w_accept    = start && w_idle && w_is_muldiv;
        w_signed    = ~funct[0];
        w_mag_a     = (w_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
        w_mag_b     = (w_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;
    end

    // One iteration of shift-add multiply or restoring divide
    always_comb begin
        w_msum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_opnd : '0)};
        w_dtop = r_acc[2*WIDTH-1:WIDTH-1];
        w_dsub = w_dtop - {1'b0, r_opnd};
        w_dge  = (w_dtop >= {1'b0, r_opnd});
        if (r_is_div) begin
            w_step = {(w_dge ? w_dsub[WIDTH-1:0] : w_dtop[WIDTH-1:0]), r_acc[WIDTH-2:0], w_dge};
        end else begin
            w_step = {w_msum, r_acc[WIDTH-1:1]};
        end
    end

    // Sign fix-up of the finished magnitude result
    always_comb begin
        w_prod = (r_sign_a ^ r_sign_b) ? (~r_acc + 1'b1) : r_acc;
        w_quot = r_acc[WIDTH-1:0];
        w_rem  = r_acc[2*WIDTH-1:WIDTH];
        // Divide by zero keeps the all-ones quotient regardless of dividend sign
        if ((r_sign_a ^ r_sign_b) && !r_div_zero) begin
            w_quot = ~r_acc[WIDTH-1:0] + 1'b1;
        end
        if (r_sign_a) begin
            w_rem = ~r_acc[2*WIDTH-1:WIDTH] + 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and busy decode
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (r_cnt == c_last) begin
                    w_state_next = S_FIX;
                end
            end
            S_FIX: begin
                busy         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Datapath: operand latch, iteration, result write-back and mthi/mtlo
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_acc      <= '0;
            r_opnd     <= '0;
            r_is_div   <= 1'b0;
            r_sign_a   <= 1'b0;
            r_sign_b   <= 1'b0;
            r_div_zero <= 1'b0;
            r_done     <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cnt      <= '0;
                        r_is_div   <= funct[1];
                        r_sign_a   <= w_signed & a[WIDTH-1];
                        r_sign_b   <= w_signed & b[WIDTH-1];
                        r_div_zero <= funct[1] && (b == '0);
                        r_opnd     <= funct[1] ? w_mag_b : w_mag_a;
                        r_acc      <= {{WIDTH{1'b0}}, (funct[1] ? w_mag_a : w_mag_b)};
                    end else if (start && funct == c_fn_mthi) begin
                        r_hi <= a;
                    end else if (start && funct == c_fn_mtlo) begin
                        r_lo <= a;
                    end
                end
                S_RUN: begin
                    r_acc <= w_step;
                    r_cnt <= (r_cnt == c_last) ? '0 : r_cnt + 1'b1;
                end
                S_FIX: begin
                    r_done <= 1'b1;
                    if (r_is_div) begin
                        r_hi <= w_rem;
                        r_lo <= w_quot;
                    end else begin
                        r_hi <= w_prod[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod[WIDTH-1:0];
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
//==============================================================================
// Module      : tb_muldiv_unit
// Description : Self-checking bench for muldiv_unit (WIDTH=32) with directed
//               corner cases and random ops against an arithmetic model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_muldiv_unit;

    localparam logic [5:0] c_mult  = 6'h18;
    localparam logic [5:0] c_multu = 6'h19;
    localparam logic [5:0] c_div   = 6'h1A;
    localparam logic [5:0] c_divu  = 6'h1B;
    localparam logic [5:0] c_mthi  = 6'h11;
    localparam logic [5:0] c_mtlo  = 6'h13;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  funct = 6'h0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;
    logic [63:0] pend = '0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .funct (funct),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    // Arithmetic reference: returns {hi, lo}
    function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
        longint sx;
        longint sy;
        longint q;
        longint r;
        logic [63:0] p;
        if (f == c_mult || f == c_div) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
        end else begin
            sx = longint'({32'b0, x});
            sy = longint'({32'b0, y});
        end
        if (f == c_mult || f == c_multu) begin
            p = sx * sy;
            return p;
        end
        if (y == 32'h0) begin
            return {x, 32'hFFFF_FFFF};
        end
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Called at a negedge: presents one request for a single edge
    task automatic issue(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        funct = f;
        a     = x;
        b     = y;
        if (f == c_mult || f == c_multu || f == c_div || f == c_divu) begin
            pend = model(f, x, y);
        end else if (f == c_mthi) begin
            exp_hi = x;
        end else if (f == c_mtlo) begin
            exp_lo = x;
        end
        @(negedge clk);
        start = 1'b0;
        funct = 6'h0;
    endtask

    // Waits for done after an accepted mult/div; checks hold, latency and result
    task automatic wait_check(input string tag, input bit inject);
        int k;
        k = 0;
        chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
        while (done !== 1'b1 && k < 60) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                chk({tag, "_hold_hi"}, hi, exp_hi);
                chk({tag, "_hold_lo"}, lo, exp_lo);
            end
            if (inject && k == 5) begin
                start = 1'b1;
                funct = c_mtlo;
                a     = 32'h0000_AAAA;
            end
            if (inject && k == 6) begin
                start = 1'b0;
                funct = 6'h0;
            end
        end
        chk({tag, "_latency"}, k, 32'd33);
        exp_hi = pend[63:32];
        exp_lo = pend[31:0];
        chk({tag, "_hi"}, hi, exp_hi);
        chk({tag, "_lo"}, lo, exp_lo);
        chk({tag, "_idle"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        logic [5:0]  fsel [4];
        logic [5:0]  f;
        logic [31:0] x;
        logic [31:0] y;
        fsel[0] = c_mult;
        fsel[1] = c_multu;
        fsel[2] = c_div;
        fsel[3] = c_divu;

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);

        // Reset in the middle of RUN discards the op
        issue(c_multu, 32'd7, 32'd6);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_hi", hi, 32'd0);
        chk("midrst_lo", lo, 32'd0);
        for (int i = 0; i < 30; i++) begin
            chk("midrst_nodone", {31'b0, done}, 32'd0);
            @(negedge clk);
        end

        // Directed corner cases
        issue(c_multu, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_check("multu_max", 1'b0);
        chk("multu_max_hi_abs", hi, 32'hFFFF_FFFE);
        chk("multu_max_lo_abs", lo, 32'h0000_0001);
        @(negedge clk);
        chk("done_one_cycle", {31'b0, done}, 32'd0);
        issue(c_mult, 32'hFFFF_FFFD, 32'd5);
        wait_check("mult_neg", 1'b0);
        issue(c_mult, 32'h8000_0000, 32'h8000_0000);
        wait_check("mult_min", 1'b0);
        chk("mult_min_hi_abs", hi, 32'h4000_0000);
        issue(c_div, 32'hFFFF_FFF9, 32'd2);
        wait_check("div_neg", 1'b0);
        chk("div_neg_lo_abs", lo, 32'hFFFF_FFFD);
        issue(c_div, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_check("div_ovf", 1'b0);
        chk("div_ovf_lo_abs", lo, 32'h8000_0000);
        issue(c_divu, 32'd100, 32'd7);
        wait_check("divu_100_7", 1'b0);
        issue(c_divu, 32'h0000_1234, 32'd0);
        wait_check("divu_zero", 1'b0);
        chk("divu_zero_lo_abs", lo, 32'hFFFF_FFFF);
        issue(c_div, 32'hFFFF_FFF9, 32'd0);
        wait_check("div_zero_neg", 1'b0);

        // mtlo while busy is ignored
        issue(c_multu, 32'd12, 32'd13);
        wait_check("busy_mtlo", 1'b1);
        chk("busy_mtlo_lo_abs", lo, 32'd156);

        // mthi while idle: one-edge latency, no done/busy
        issue(c_mthi, 32'h0000_5555, 32'd0);
        chk("mthi_hi", hi, 32'h0000_5555);
        chk("mthi_done", {31'b0, done}, 32'd0);
        chk("mthi_busy", {31'b0, busy}, 32'd0);
        issue(c_mtlo, 32'h1357_9BDF, 32'd0);
        chk("mtlo_lo", lo, 32'h1357_9BDF);
        chk("mtlo_hi", hi, exp_hi);

        // Invalid funct causes no change
        issue(6'h20, 32'hDEAD_BEEF, 32'h1);
        chk("inv_hi", hi, exp_hi);
        chk("inv_lo", lo, exp_lo);
        chk("inv_busy", {31'b0, busy}, 32'd0);

        // Back-to-back: second op issued in the done cycle
        issue(c_mult, 32'h0001_2345, 32'hFFFF_0000);
        wait_check("b2b_1", 1'b0);
        issue(c_mult, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        wait_check("b2b_2", 1'b0);

        // Random ops against the model, chained back-to-back
        for (int i = 0; i < 40; i++) begin
            f = fsel[$urandom_range(0, 3)];
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 5))
                0: y = 32'h0;
                1: y = $urandom_range(1, 20);
                2: y = 32'hFFFF_FFFF;
                3: x = 32'h8000_0000;
                default: ;
            endcase
            issue(f, x, y);
            wait_check("rand", 1'b0);
        end

        @(negedge clk);
        chk("final_nodone", {31'b0, done}, 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global bound in case the design stalls in an unexpected way
    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
